// File: rtl/usb2_crc_stream.sv
// ----------------------------------------------------------------------------
// usb2_crc_stream
//
// Parametrised streaming USB 2.0 CRC engine. Packet data arrives in beats of
// up to DATA_W bits (bit 0 on the wire first). A whole beat is folded into the
// CRC register in one cycle. When the last beat of a packet is accepted, the
// result is presented on the next cycle and held until the consumer takes it.
// The same block serves TX (append out_crc) and RX (check out_ok against the
// good-packet residual).
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   engine can accept a beat (depends only on FSM state)
//   in_sop     first beat of packet; reseeds the register to all ones
//   in_eop     last beat of packet
//   in_data    beat data, LSB-aligned, bit 0 first
//   in_nbits   valid bits on an eop beat (0 or > DATA_W means DATA_W)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_crc    bit-reversed complement of the register (bit 0 sent first)
//   out_ok     register equals RESIDUAL (RX good-packet check)
//   busy       packet in progress, from sop accept to result accept
// ----------------------------------------------------------------------------
module usb2_crc_stream #(
    parameter int                 CRC_W    = 16,
    parameter logic [CRC_W-1:0]   POLY     = 16'h8005,
    parameter logic [CRC_W-1:0]   RESIDUAL = 16'h800D,
    parameter int                 DATA_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [$clog2(DATA_W+1)-1:0]   in_nbits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CRC_W-1:0]              out_crc,
    output logic                          out_ok,
    output logic                          busy
);

    localparam int               NB_W    = $clog2(DATA_W + 1);
    localparam logic [NB_W-1:0]  DATA_NB = NB_W'(DATA_W);
    localparam logic [CRC_W-1:0] SEED    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CRC_W-1:0]  r_crc;
    logic [CRC_W-1:0]  w_crc_next;
    logic [CRC_W-1:0]  w_fold;
    logic [NB_W-1:0]   w_nbits;
    logic              w_fire;

    // Serial CRC step unrolled across the beat; bits at or above nbits are
    // skipped so a partial last beat folds only its valid low-order bits.
    function automatic logic [CRC_W-1:0] fold_bits(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] data,
        input logic [NB_W-1:0]   nbits
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (NB_W'(i) < nbits) begin
                fb = data[i] ^ c[CRC_W-1];
                c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        return c;
    endfunction

    // Non-eop beats are always full width; on eop, 0 and oversize counts both
    // collapse to DATA_W.
    always_comb begin
        w_nbits = DATA_NB;
        if (in_eop && (in_nbits != '0) && (in_nbits < DATA_NB)) begin
            w_nbits = in_nbits;
        end
    end

    // A sop beat always starts from the seed, which also covers the abort
    // case where a new sop arrives while a packet is still accumulating.
    assign w_fold = fold_bits(in_sop ? SEED : r_crc, in_data, w_nbits);
    assign w_fire = in_valid && in_ready;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned; otherwise synthesis infers latches.
    always_comb begin
        w_next_state = r_state;
        w_crc_next   = r_crc;
        in_ready     = 1'b1;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_fire && in_sop) begin
                    w_crc_next   = w_fold;
                    w_next_state = in_eop ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_fire) begin
                    w_crc_next   = w_fold;
                    w_next_state = in_eop ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_crc   <= SEED;
        end else begin
            r_state <= w_next_state;
            r_crc   <= w_crc_next;
        end
    end

    // The register holds the CRC MSB-first; the wire wants it LSB-first and
    // inverted. With the all-ones seed this reads as zero straight out of reset.
    always_comb begin
        out_crc = '0;
        for (int i = 0; i < CRC_W; i++) begin
            out_crc[i] = ~r_crc[CRC_W-1-i];
        end
    end

    assign out_ok = (r_state == S_DONE) && (r_crc == RESIDUAL);

endmodule

// File: tb/tb_usb2_crc_stream.sv
// ----------------------------------------------------------------------------
// tb_usb2_crc_stream
//
// Directed bench for usb2_crc_stream. Three instances share clock and reset:
//   u_a : CRC-5,  11-bit beats (full token in one beat)
//   u_b : CRC-5,  8-bit beats  (token split over beats, partial eop)
//   u_c : CRC-16, 8-bit beats  (data packets, RX residual check)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_usb2_crc_stream;

    logic clk;
    logic reset_n;

    // instance a
    logic        a_in_valid, a_in_ready, a_in_sop, a_in_eop;
    logic [10:0] a_in_data;
    logic [3:0]  a_in_nbits;
    logic        a_out_valid, a_out_ready, a_out_ok, a_busy;
    logic [4:0]  a_out_crc;

    // instance b
    logic        b_in_valid, b_in_ready, b_in_sop, b_in_eop;
    logic [7:0]  b_in_data;
    logic [3:0]  b_in_nbits;
    logic        b_out_valid, b_out_ready, b_out_ok, b_busy;
    logic [4:0]  b_out_crc;

    // instance c
    logic        c_in_valid, c_in_ready, c_in_sop, c_in_eop;
    logic [7:0]  c_in_data;
    logic [3:0]  c_in_nbits;
    logic        c_out_valid, c_out_ready, c_out_ok, c_busy;
    logic [15:0] c_out_crc;

    int          n_vec;
    int          n_miss;
    logic [7:0]  pkt [0:65];
    int          len;
    int          bitn;
    logic [15:0] exp16;

    usb2_crc_stream #(.CRC_W(5), .POLY(5'h05), .RESIDUAL(5'h0C), .DATA_W(11)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sop(a_in_sop),
        .in_eop(a_in_eop), .in_data(a_in_data), .in_nbits(a_in_nbits),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_crc(a_out_crc),
        .out_ok(a_out_ok), .busy(a_busy)
    );

    usb2_crc_stream #(.CRC_W(5), .POLY(5'h05), .RESIDUAL(5'h0C), .DATA_W(8)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sop(b_in_sop),
        .in_eop(b_in_eop), .in_data(b_in_data), .in_nbits(b_in_nbits),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_crc(b_out_crc),
        .out_ok(b_out_ok), .busy(b_busy)
    );

    usb2_crc_stream #(.CRC_W(16), .POLY(16'h8005), .RESIDUAL(16'h800D), .DATA_W(8)) u_c (
        .clk(clk), .reset_n(reset_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sop(c_in_sop),
        .in_eop(c_in_eop), .in_data(c_in_data), .in_nbits(c_in_nbits),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_crc(c_out_crc),
        .out_ok(c_out_ok), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sequence still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic sop, input logic eop, input logic [10:0] d, input logic [3:0] nb);
        a_in_valid = 1'b1; a_in_sop = sop; a_in_eop = eop; a_in_data = d; a_in_nbits = nb;
        tick();
        a_in_valid = 1'b0; a_in_sop = 1'b0; a_in_eop = 1'b0;
    endtask

    task automatic b_beat(input logic sop, input logic eop, input logic [7:0] d, input logic [3:0] nb);
        b_in_valid = 1'b1; b_in_sop = sop; b_in_eop = eop; b_in_data = d; b_in_nbits = nb;
        tick();
        b_in_valid = 1'b0; b_in_sop = 1'b0; b_in_eop = 1'b0;
    endtask

    task automatic c_beat(input logic sop, input logic eop, input logic [7:0] d, input logic [3:0] nb);
        c_in_valid = 1'b1; c_in_sop = sop; c_in_eop = eop; c_in_data = d; c_in_nbits = nb;
        tick();
        c_in_valid = 1'b0; c_in_sop = 1'b0; c_in_eop = 1'b0;
    endtask

    task automatic c_send(input int n);
        for (int i = 0; i < n; i++) begin
            c_beat(i == 0, i == n - 1, pkt[i], 4'd0);
        end
    endtask

    // Reflected-form USB CRC-16 (poly 0xA001, LSB-first, init all ones,
    // complemented result) over pkt[0..n-1].
    function automatic logic [15:0] usb_crc16(input int n);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (r[0] ^ pkt[k][j]) r = (r >> 1) ^ 16'hA001;
                else                  r = r >> 1;
            end
        end
        return ~r;
    endfunction

    initial begin
        n_vec = 0; n_miss = 0;
        reset_n = 1'b0;
        a_in_valid = 0; a_in_sop = 0; a_in_eop = 0; a_in_data = '0; a_in_nbits = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_sop = 0; b_in_eop = 0; b_in_data = '0; b_in_nbits = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_sop = 0; c_in_eop = 0; c_in_data = '0; c_in_nbits = '0; c_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst a in_ready",  32'(a_in_ready),  32'd1);
        check("rst a out_valid", 32'(a_out_valid), 32'd0);
        check("rst a out_crc",   32'(a_out_crc),   32'h0);
        check("rst a out_ok",    32'(a_out_ok),    32'd0);
        check("rst a busy",      32'(a_busy),      32'd0);
        check("rst c out_crc",   32'(c_out_crc),   32'h0);
        check("rst c out_ok",    32'(c_out_ok),    32'd0);
        check("rst b in_ready",  32'(b_in_ready),  32'd1);

        reset_n = 1'b1;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        tick();

        // 11-bit zero token in one beat, result held under backpressure
        a_beat(1'b1, 1'b1, 11'h000, 4'd0);
        check("a tok out_valid", 32'(a_out_valid), 32'd1);
        check("a tok out_crc",   32'(a_out_crc),   32'h02);
        check("a tok in_ready",  32'(a_in_ready),  32'd0);
        check("a tok busy",      32'(a_busy),      32'd1);
        check("a tok out_ok",    32'(a_out_ok),    32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("a hold out_valid", 32'(a_out_valid), 32'd1);
            check("a hold out_crc",   32'(a_out_crc),   32'h02);
            check("a hold in_ready",  32'(a_in_ready),  32'd0);
        end
        a_out_ready = 1'b1;
        tick();
        check("a ack out_valid", 32'(a_out_valid), 32'd0);
        check("a ack busy",      32'(a_busy),      32'd0);
        check("a ack in_ready",  32'(a_in_ready),  32'd1);

        // Token followed by its CRC (5-bit partial eop beat) hits the residual
        a_beat(1'b1, 1'b0, 11'h000, 4'd0);
        check("a rx mid out_valid", 32'(a_out_valid), 32'd0);
        a_beat(1'b0, 1'b1, 11'h002, 4'd5);
        check("a rx out_valid", 32'(a_out_valid), 32'd1);
        check("a rx out_ok",    32'(a_out_ok),    32'd1);
        check("a rx out_crc",   32'(a_out_crc),   32'h19);
        tick();

        // Same token as 8 + 3 bits
        b_beat(1'b1, 1'b0, 8'h00, 4'd0);
        check("b split mid out_valid", 32'(b_out_valid), 32'd0);
        check("b split mid busy",      32'(b_busy),      32'd1);
        b_beat(1'b0, 1'b1, 8'h00, 4'd3);
        check("b split out_valid", 32'(b_out_valid), 32'd1);
        check("b split out_crc",   32'(b_out_crc),   32'h02);
        tick();

        // Token + CRC as two full bytes
        b_beat(1'b1, 1'b0, 8'h00, 4'd0);
        b_beat(1'b0, 1'b1, 8'h10, 4'd0);
        check("b rx out_ok",  32'(b_out_ok),  32'd1);
        check("b rx out_crc", 32'(b_out_crc), 32'h19);
        tick();

        // nbits above DATA_W clamps to a full 8-bit beat
        b_beat(1'b1, 1'b1, 8'h00, 4'd12);
        check("b clamp out_crc", 32'(b_out_crc), 32'h01);
        tick();
        b_beat(1'b1, 1'b1, 8'h00, 4'd0);
        check("b nbits0 out_crc", 32'(b_out_crc), 32'h01);
        tick();

        // Beat without sop in IDLE is dropped
        b_beat(1'b0, 1'b1, 8'hFF, 4'd0);
        check("b drop out_valid", 32'(b_out_valid), 32'd0);
        check("b drop busy",      32'(b_busy),      32'd0);
        check("b drop in_ready",  32'(b_in_ready),  32'd1);

        // Abort: three beats, new sop, then the token alone
        b_beat(1'b1, 1'b0, 8'hFF, 4'd0);
        check("b abort1 out_valid", 32'(b_out_valid), 32'd0);
        b_beat(1'b0, 1'b0, 8'h5A, 4'd0);
        check("b abort2 out_valid", 32'(b_out_valid), 32'd0);
        b_beat(1'b0, 1'b0, 8'h33, 4'd0);
        check("b abort3 out_valid", 32'(b_out_valid), 32'd0);
        b_beat(1'b1, 1'b0, 8'h00, 4'd0);
        check("b resop out_valid", 32'(b_out_valid), 32'd0);
        b_beat(1'b0, 1'b1, 8'h00, 4'd3);
        check("b abort out_valid", 32'(b_out_valid), 32'd1);
        check("b abort out_crc",   32'(b_out_crc),   32'h02);
        tick();
        check("b abort single", 32'(b_out_valid), 32'd0);

        // CRC-16: two zero bytes (empty payload + its CRC) land on the residual
        c_beat(1'b1, 1'b0, 8'h00, 4'd0);
        c_beat(1'b0, 1'b1, 8'h00, 4'd0);
        check("c zero out_ok",  32'(c_out_ok),  32'd1);
        check("c zero out_crc", 32'(c_out_crc), 32'h4FFE);
        tick();

        // CRC-16 TX then RX on a random-length payload, then a single-bit error
        len = $urandom_range(1, 64);
        for (int i = 0; i < len; i++) pkt[i] = 8'($urandom_range(0, 255));
        exp16 = usb_crc16(len);
        c_send(len);
        check("c tx out_crc", 32'(c_out_crc), 32'(exp16));
        tick();
        pkt[len]     = exp16[7:0];
        pkt[len + 1] = exp16[15:8];
        c_send(len + 2);
        check("c rx out_ok", 32'(c_out_ok), 32'd1);
        tick();
        bitn = $urandom_range(0, (len + 2) * 8 - 1);
        pkt[bitn / 8][bitn % 8] = ~pkt[bitn / 8][bitn % 8];
        c_send(len + 2);
        check("c rx flip out_ok", 32'(c_out_ok), 32'd0);
        tick();

        // Reset while accumulating
        b_beat(1'b1, 1'b0, 8'hFF, 4'd0);
        check("b accum busy", 32'(b_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("b rst accum in_ready",  32'(b_in_ready),  32'd1);
        check("b rst accum busy",      32'(b_busy),      32'd0);
        check("b rst accum out_valid", 32'(b_out_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        b_beat(1'b1, 1'b0, 8'h00, 4'd0);
        b_beat(1'b0, 1'b1, 8'h00, 4'd3);
        check("b post rst1 out_crc", 32'(b_out_crc), 32'h02);
        tick();

        // Reset while holding a result
        b_out_ready = 1'b0;
        b_beat(1'b1, 1'b1, 8'h00, 4'd0);
        check("b done out_valid", 32'(b_out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("b rst done out_valid", 32'(b_out_valid), 32'd0);
        check("b rst done busy",      32'(b_busy),      32'd0);
        check("b rst done in_ready",  32'(b_in_ready),  32'd1);
        check("b rst done out_crc",   32'(b_out_crc),   32'h0);
        tick();
        reset_n = 1'b1;
        b_out_ready = 1'b1;
        b_beat(1'b1, 1'b0, 8'h00, 4'd0);
        b_beat(1'b0, 1'b1, 8'h00, 4'd3);
        check("b post rst2 out_crc", 32'(b_out_crc), 32'h02);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/usb2_crc_stream.md
Name: usb2_crc_stream

Overview:
Parametrised, pipelined USB 2.0 CRC engine for streamed packet data. It generalises the fixed 11-bit combinational CRC-5 to any CRC width and polynomial, any beat width, and partial last beats. Sits between the ULPI/packet layer and the token/data packet handlers. One instance per direction:
- TX: generates the CRC to append to outgoing packets.
- RX: checks incoming packet+CRC against the USB residual.

Parameters:
CRC_W, 16, CRC register width (5 for tokens/SOF, 16 for data packets)
POLY, 16'h8005, generator polynomial without implicit x^CRC_W term (CRC-5 uses 5'h05)
RESIDUAL, 16'h800D, good-packet residual (CRC-5 uses 5'h0C)
DATA_W, 8, bits per input beat, 1..16

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept a beat
in_sop  in  1  first beat of packet; reloads CRC to all-ones before the beat
in_eop  in  1  last beat of packet
in_data  in  DATA_W  beat data, bit 0 transmitted first
in_nbits  in  $clog2(DATA_W+1)  valid bits in the beat, LSB-aligned; used only on in_eop beats (0 means DATA_W)
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  consumer accepts result
out_crc  out  CRC_W  CRC to transmit; bit 0 sent first
out_ok  out  1  final register equals RESIDUAL (RX check)
busy  out  1  packet in progress (between sop accept and result accept)

Behaviour:
- Reset: in_ready=1, out_valid=0, out_crc=0, out_ok=0, busy=0. CRC register=all ones. FSM=IDLE.
- Beat transfer: occurs when in_valid && in_ready.
- Per-bit update, LSB of in_data first:
  - fb = d ^ crc[CRC_W-1]
  - crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - One beat (up to DATA_W bits) is folded in a single cycle, combinationally unrolled.
- out_crc = bit-reversed complement of the register: out_crc[i] = ~crc[CRC_W-1-i].
- out_ok = (crc == RESIDUAL) after the final beat.
- FSM states:
  - IDLE: in_ready=1. Beats without in_sop are dropped; no state change, no error.
    - Beat with in_sop: register seeded with all ones, beat folded, busy=1. Go to ACCUM, or to DONE if in_eop is also set.
  - ACCUM: in_ready=1. Each beat is folded.
    - in_eop beat folds only in_nbits bits, then goes to DONE.
    - in_sop in ACCUM aborts the current packet: register reseeded, beat folded as a new first beat. No result is emitted for the aborted packet.
  - DONE: out_valid=1, in_ready=0. out_crc/out_ok are stable.
    - out_valid && out_ready: go to IDLE, busy=0. in_ready rises the following cycle.
- Latency: result is visible on the cycle after the eop beat is accepted. Throughput is one beat/cycle within a packet, plus one bubble cycle per packet minimum.
- Zero-length packet: sop+eop beat with in_nbits treated as given. Because nbits=0 means DATA_W, a true empty payload is signalled by a sop+eop beat that the caller marks with a separate 0-bit convention. This is not supported: packet layer supplies at least one bit. CRC of empty payload is a constant (~all-ones = 0) handled upstream.
- in_nbits > DATA_W on an eop beat: clamped to DATA_W.
- Backpressure: in_ready depends only on FSM state (registered), never combinationally on in_valid.
- Reset mid-packet: all state cleared immediately; any pending result is discarded.

Test Plan:
- CRC_W=5, POLY=5'h05, DATA_W=11: one sop+eop beat, in_data=11'h000 -> out_valid next cycle, out_crc=5'h02. Hold out_ready=0 for 3 cycles: out_crc stable, in_ready=0.
- CRC_W=5, DATA_W=8: beats 8'h00 then 8'h00 with in_eop and in_nbits=3 -> out_crc=5'h02, identical to the single 11-bit beat.
- CRC_W=16, DATA_W=8, RX check: random 1..64-byte payload followed by its two CRC bytes (from a TX-mode run) -> out_ok=1. Flip any single bit -> out_ok=0.
- CRC_W=16: payload 16'h0000 as two bytes (CRC of empty packet), one packet -> final register 16'h800D, out_ok=1.
- Abort: sop, 3 beats, then new sop without eop, then a valid 11-bit token -> exactly one result, matching the token alone.
- Reset: assert reset_n=0 in ACCUM and in DONE -> out_valid=0, busy=0, in_ready=1 asynchronously. Next packet's CRC is unaffected by the prior state.
